// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: RX byte FIFO, TX holding register
// and a three-state TX handshake FSM behind four CPU registers.
module uart_mmio_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  hit,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_parity_err,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  input  logic                  tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_RX =
    ADDR_WIDTH'(32'h1001_0030);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TXD =
    ADDR_WIDTH'(32'h1001_0034);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ST =
    ADDR_WIDTH'(32'h1001_0038);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TXS =
    ADDR_WIDTH'(32'h1001_003C);

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_BUSY
  } tx_state_e;

  tx_state_e r_state;
  tx_state_e w_next;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic          r_ovf;
  logic          r_par;
  logic [7:0]    r_hold;

  logic          w_sel_rx;
  logic          w_sel_txd;
  logic          w_sel_st;
  logic          w_sel_txs;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_wr_st;
  logic          w_busy;
  logic          w_tx_start;
  logic [PW-1:0] w_cnt;
  logic [31:0]   w_cnt32;
  logic [2:0]    w_cnt_sat;
  logic [7:0]    w_status;
  logic [7:0]    w_head;
  logic [DATA_WIDTH-1:0] w_rd;

  assign w_sel_rx  = (A == ADDR_RX);
  assign w_sel_txd = (A == ADDR_TXD);
  assign w_sel_st  = (A == ADDR_ST);
  assign w_sel_txs = (A == ADDR_TXS);
  assign hit = w_sel_rx | w_sel_txd | w_sel_st | w_sel_txs;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[PW-1] != r_rp[PW-1]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_head  = r_mem[r_rp[AW-1:0]];

  // A pop frees a slot in the same edge, so a full FIFO can still accept.
  assign w_pop     = re & w_sel_rx & ~w_empty;
  assign w_push    = rx_valid & (~w_full | w_pop);
  assign w_ovf_set = rx_valid & w_full & ~w_pop;
  assign w_wr_st   = we & w_sel_st;

  assign w_cnt     = r_wp - r_rp;
  assign w_cnt32   = 32'(w_cnt);
  assign w_cnt_sat = (w_cnt32 > 32'd7) ? 3'd7 : w_cnt32[2:0];
  assign w_busy    = (r_state != T_IDLE);
  assign w_status  = {1'b0, w_cnt_sat, r_par, r_ovf,
                      w_busy, ~w_empty};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      r_par <= 1'b0;
    end else begin
      if (w_pop)
        r_rp <= r_rp + PW'(1);
      if (w_push)
        r_wp <= r_wp + PW'(1);
      if (w_wr_st && WD[2])
        r_ovf <= 1'b0;
      else if (w_ovf_set)
        r_ovf <= 1'b1;
      if (w_wr_st && WD[3])
        r_par <= 1'b0;
      else if (rx_valid && rx_parity_err)
        r_par <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_hold <= 8'h00;
    else if (we && w_sel_txd && r_state == T_IDLE)
      r_hold <= WD[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= T_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    unique case (r_state)
      T_IDLE:
        if (we && w_sel_txs && (|WD))
          w_next = T_START;
      T_START: begin
        w_tx_start = 1'b1;
        w_next     = T_BUSY;
      end
      T_BUSY:
        if (tx_done)
          w_next = T_IDLE;
      default:
        w_next = T_IDLE;
    endcase
  end

  assign tx_start = w_tx_start;
  assign tx_byte  = r_hold;

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_sel_rx:
        if (!w_empty)
          w_rd = DATA_WIDTH'(w_head);
      w_sel_txd: w_rd = DATA_WIDTH'(r_hold);
      w_sel_st:  w_rd = DATA_WIDTH'(w_status);
      w_sel_txs: w_rd = DATA_WIDTH'(w_busy);
      default:   w_rd = '0;
    endcase
  end

  assign RD = re ? w_rd : '0;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: register map, TX handshake,
// RX FIFO boundaries, sticky flags and mid-frame reset.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] RXD = 32'h1001_0030;
  localparam logic [31:0] TXD = 32'h1001_0034;
  localparam logic [31:0] STA = 32'h1001_0038;
  localparam logic [31:0] TXS = 32'h1001_003C;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] WD;
  logic        we;
  logic        re;
  logic [31:0] RD;
  logic        hit;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_parity_err;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  uart_mmio_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .WD(WD),
    .we(we),
    .re(re),
    .RD(RD),
    .hit(hit),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .rx_parity_err(rx_parity_err),
    .tx_start(tx_start),
    .tx_byte(tx_byte),
    .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst && tx_start) starts++;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    A = a; WD = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; WD = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    A = a; re = 1'b1;
    #1 d = RD;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic p);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = b; rx_parity_err = p;
    @(negedge clk);
    rx_valid = 1'b0; rx_parity_err = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: got start=%b byte=%h expected 0/00",
               tx_start, tx_byte);
    end
    @(negedge clk);
    rst = 1'b1;
    rd(STA, d);
    chk("reset_status", d, 32'h0);
    rd(TXD, d);
    chk("reset_hold", d, 32'h0);
    @(negedge clk);
    A = 32'h1001_0040; re = 1'b1;
    #1;
    chk("miss_hit", {31'b0, hit}, 32'h0);
    chk("miss_rd", RD, 32'h0);
    A = 32'h1001_003C;
    #1;
    chk("txs_hit", {31'b0, hit}, 32'h1);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic test_tx();
    logic [31:0] d;
    int s0;
    s0 = starts;
    wr(TXD, 32'h41);
    rd(TXD, d);
    chk("txdata_rb", d, 32'h41);
    wr(TXS, 32'h0);
    rd(STA, d);
    chk("txsend0_noop", d, 32'h0);
    chk("txsend0_nostart", starts - s0, 0);
    @(negedge clk);
    A = TXS; WD = 32'h1; we = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b1;
    #1;
    chk("tx_start_n1", {31'b0, tx_start}, 32'h1);
    chk("tx_byte", {24'b0, tx_byte}, 32'h41);
    chk("txsend_busy_n1", RD, 32'h1);
    @(negedge clk);
    re = 1'b0;
    #1;
    chk("tx_start_1cyc", {31'b0, tx_start}, 32'h0);
    rd(STA, d);
    chk("status_busy", d, 32'h2);
    wr(TXD, 32'h55);
    wr(TXS, 32'h1);
    #1;
    chk("busy_hold", {24'b0, tx_byte}, 32'h41);
    chk("busy_one_start", starts - s0, 1);
    rd(STA, d);
    chk("still_busy", d, 32'h2);
    pulse_done();
    rd(STA, d);
    chk("idle_after_done", d, 32'h0);
    rd(TXS, d);
    chk("txsend_idle", d, 32'h0);
    pulse_done();
    chk("stray_done", starts - s0, 1);
  endtask

  task automatic test_fifo_overrun();
    logic [31:0] d;
    for (int i = 0; i < 5; i++)
      push(8'h10 + 8'(i), 1'b0);
    rd(STA, d);
    chk("ovr_status", d, 32'h45);
    for (int i = 0; i < 4; i++) begin
      rd(RXD, d);
      chk("ovr_read", d, 32'h10 + i);
    end
    rd(RXD, d);
    chk("empty_read", d, 32'h0);
    rd(STA, d);
    chk("ovr_sticky", d, 32'h4);
    wr(STA, 32'h4);
    rd(STA, d);
    chk("ovr_clear", d, 32'h0);
  endtask

  task automatic test_full_pop_push();
    logic [31:0] d;
    for (int i = 0; i < 4; i++)
      push(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    A = RXD; re = 1'b1;
    rx_valid = 1'b1; rx_byte = 8'h99;
    #1;
    chk("full_pp_rd", RD, 32'h10);
    @(negedge clk);
    re = 1'b0; rx_valid = 1'b0;
    rd(STA, d);
    chk("full_pp_status", d, 32'h41);
    for (int i = 0; i < 3; i++) begin
      rd(RXD, d);
      chk("full_pp_read", d, 32'h11 + i);
    end
    rd(RXD, d);
    chk("full_pp_last", d, 32'h99);
  endtask

  task automatic test_empty_pop_push();
    logic [31:0] d;
    @(negedge clk);
    A = RXD; re = 1'b1;
    rx_valid = 1'b1; rx_byte = 8'h5A;
    #1;
    chk("empty_pp_rd", RD, 32'h0);
    @(negedge clk);
    re = 1'b0; rx_valid = 1'b0;
    rd(STA, d);
    chk("empty_pp_status", d, 32'h11);
    rd(RXD, d);
    chk("empty_pp_data", d, 32'h5A);
  endtask

  task automatic test_parity();
    logic [31:0] d;
    push(8'h7E, 1'b1);
    rd(STA, d);
    chk("par_set", d, 32'h19);
    wr(STA, 32'h8);
    rd(STA, d);
    chk("par_clear", d, 32'h11);
    rd(RXD, d);
    chk("par_byte", d, 32'h7E);
    @(negedge clk);
    A = STA; WD = 32'h8; we = 1'b1;
    rx_valid = 1'b1; rx_byte = 8'hC3; rx_parity_err = 1'b1;
    @(negedge clk);
    we = 1'b0; rx_valid = 1'b0; rx_parity_err = 1'b0;
    rd(STA, d);
    chk("par_clear_wins", d, 32'h11);
    rd(RXD, d);
    chk("par_clear_byte", d, 32'hC3);
    wr(32'h1001_0020, 32'hFF);
    rd(TXD, d);
    chk("unmapped_wr", d, 32'h41);
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    int s0;
    wr(TXD, 32'h33);
    wr(TXS, 32'h1);
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    rd(STA, d);
    chk("pre_reset_status", d, 32'h23);
    @(negedge clk);
    rst = 1'b0; A = STA; re = 1'b1;
    #1;
    chk("rst_status", RD, 32'h0);
    checks++;
    if (tx_start !== 1'b0 || tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL rst_tx: got start=%b byte=%h expected 0/00",
               tx_start, tx_byte);
    end
    @(negedge clk);
    re = 1'b0; rst = 1'b1;
    s0 = starts;
    pulse_done();
    rd(STA, d);
    chk("post_rst_done", d, 32'h0);
    chk("post_rst_nostart", starts - s0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; A = TXS; WD = 32'h1; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("first_edge_start", {31'b0, tx_start}, 32'h1);
    pulse_done();
    rd(STA, d);
    chk("b2b_idle", d, 32'h0);
  endtask

  initial begin
    rst = 1'b0; A = '0; WD = '0; we = 1'b0; re = 1'b0;
    rx_valid = 1'b0; rx_byte = '0; rx_parity_err = 1'b0;
    tx_done = 1'b0;
    test_reset();
    test_tx();
    test_fifo_overrun();
    test_full_pop_push();
    test_empty_pop_push();
    test_parity();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning CPU data bus width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning CPU address bus width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning RX FIFO entries.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 A  input  ADDR_WIDTH  CPU address.
REQ-008 WD  input  DATA_WIDTH  CPU write data.
REQ-009 we  input  1  CPU write strobe, one cycle per store.
REQ-010 re  input  1  CPU read strobe, one cycle per load.
REQ-011 RD  output  DATA_WIDTH  read data; combinational; 0 unless re and address hit.
REQ-012 hit  output  1  A is one of the four UART addresses.
REQ-013 rx_valid  input  1  one-cycle pulse from UART RX: byte received.
REQ-014 rx_byte  input  8  received byte, valid with rx_valid.
REQ-015 rx_parity_err  input  1  parity error flag, valid with rx_valid.
REQ-016 tx_start  output  1  one-cycle pulse to UART TX: begin frame.
REQ-017 tx_byte  output  8  byte to transmit; held stable from tx_start until tx_done.
REQ-018 tx_done  input  1  one-cycle pulse from UART TX at end of stop bit.

Function
REQ-019 Map: 0x10010030 RXDATA (R), 0x10010034 TXDATA (W), 0x10010038 STATUS (R/W), 0x1001003C TXSEND (R/W); any other A -> hit=0, no effect.
REQ-020 STATUS bits: [0] rx_ready (FIFO non-empty), [1] tx_busy, [2] rx_overrun (sticky), [3] parity_err (sticky), [6:4] FIFO count (saturates at 7), upper bits 0.
REQ-021 Write to STATUS with WD[2]=1 clears overrun, WD[3]=1 clears parity_err; clear wins over same-cycle set.
REQ-022 Read RXDATA: RD={0,head byte}; FIFO pops on that clock edge; read when empty returns 0, no pointer change.
REQ-023 RX push on rx_valid when not full; rx_parity_err=1 sets parity_err and byte is still pushed.
REQ-024 rx_valid while full and no same-cycle pop: byte dropped, rx_overrun set.
REQ-025 rx_valid while full with same-cycle pop: pop then push, byte accepted, no overrun.
REQ-026 rx_valid while empty with same-cycle RXDATA read: RD=0, byte pushed, count becomes 1.
REQ-027 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full/empty from MSB compare.
REQ-028 Write TXDATA in T_IDLE loads holding register with WD[7:0]; ignored in T_START/T_BUSY.
REQ-029 TX FSM states: T_IDLE, T_START, T_BUSY.
REQ-030 T_IDLE -> T_START on write TXSEND with |WD=1; write of 0 no effect.
REQ-031 T_START: tx_start=1 for exactly this one cycle, then unconditionally -> T_BUSY.
REQ-032 T_BUSY -> T_IDLE on tx_done; tx_done in other states ignored.
REQ-033 tx_busy=1 in T_START and T_BUSY; TXSEND write while busy ignored (no queueing).
REQ-034 Read TXSEND: RD={0,tx_busy}; read TXDATA returns holding register in [7:0].
REQ-035 Latency: TXSEND write in cycle N -> tx_start high in cycle N+1; tx_busy reads 1 from N+1.

Reset
REQ-036 On rst low, immediately: FSM=T_IDLE, tx_start=0, holding register=0x00, FIFO empty, pointers 0, sticky bits 0.
REQ-037 Reset mid-frame SHALL abandon the frame; a later tx_done is ignored.
REQ-038 First edge after rst deasserts SHALL behave as normal operation, no extra wait.

Verification
REQ-039 Write TXDATA=0x41, TXSEND=1 -> tx_start one cycle, tx_byte=0x41; STATUS[1]=1 until tx_done, then 0.
REQ-040 In T_BUSY write TXDATA=0x55 and TXSEND=1 -> tx_byte stays 0x41, no second tx_start.
REQ-041 Push 0x10,0x11,0x12,0x13, then 0x14 -> count=4, overrun=1; reads return 0x10..0x13, fifth read 0.
REQ-042 FIFO full, rx_valid 0x99 same cycle as RXDATA read -> RD=0x10, overrun stays 0, last read gives 0x99.
REQ-043 rx_valid with parity_err=1 byte 0x7E -> STATUS=0x19; write STATUS WD=0x8 -> STATUS=0x11.
REQ-044 Assert rst in T_BUSY with 2 FIFO bytes -> STATUS=0, tx_start=0; later tx_done leaves FSM in T_IDLE.
